// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: framing bytes and controller state encoding shared by the boot loader.
package imem_boot_pkg;
  localparam logic [7:0] SOF = 8'hFE;
  localparam logic [7:0] EOF = 8'hFF;
  localparam logic [7:0] ESC = 8'hFD;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ESC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs bytes MSB-first into 32-bit words, zero-padding on flush.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        pack_i,
  input  logic        flush_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] pack_q, pack_d;
  // Unfilled low bytes of pack_q are always zero, so OR-ing in the new byte is enough.
  always_comb begin
    word_o       = pack_q | (pack_i ? ({byte_i, 24'h0} >> {idx_q, 3'b000}) : 32'h0);
    word_valid_o = (pack_i && idx_q == 2'd3) || (flush_i && idx_q != 2'd0);
    idx_d        = (clr_i || flush_i) ? 2'd0 : idx_q + {1'b0, pack_i};
    pack_d       = (clr_i || flush_i || word_valid_o) ? 32'h0 : word_o;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= 2'd0;
      pack_q <= 32'h0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
    end
  end
endmodule

// File: rtl/imem_boot_loader_ctrl.sv
// imem_boot_loader_ctrl: deframes a boot byte stream into instruction-memory word writes
// and holds the core in reset until a complete image has been loaded.
module imem_boot_loader_ctrl
  import imem_boot_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_byte_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          core_run_o,
  output logic          busy_o,
  output logic          err_o,
  output logic [AW:0]   word_cnt_o
);
  state_e        state_q, state_d;
  logic          ready_q, we_q, run_q, busy_q, err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [AW:0]   cnt_q;
  logic          acc, full, pack, flush, clr, word_valid;
  logic [31:0]   word;
  assign acc  = rx_valid_i & ready_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  imem_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr),
    .pack_i      (pack),
    .flush_i     (flush),
    .byte_i      (rx_byte_i),
    .word_valid_o(word_valid),
    .word_o      (word)
  );
  always_comb begin
    state_d = state_q;
    pack    = 1'b0;
    flush   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (acc && rx_byte_i == SOF) begin
        state_d = ST_LOAD;
        clr     = 1'b1;
      end
      ST_LOAD: if (acc) begin
        if (rx_byte_i == ESC) state_d = ST_ESC;
        else if (rx_byte_i == EOF) begin
          state_d = ST_FLUSH;
          flush   = 1'b1;
        end else if (rx_byte_i == SOF || full) state_d = ST_ERR;
        else pack = 1'b1;
      end
      ST_ESC: if (acc) begin
        state_d = full ? ST_ERR : ST_LOAD;
        pack    = !full;
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d != ST_FLUSH;
      run_q   <= state_d == ST_DONE;
      busy_q  <= state_d inside {ST_LOAD, ST_ESC, ST_FLUSH};
      err_q   <= state_d == ST_ERR;
      we_q    <= word_valid;
      if (word_valid) begin
        addr_q  <= cnt_q[AW-1:0];
        wdata_q <= word;
      end
      cnt_q   <= clr ? '0 : cnt_q + (AW+1)'(word_valid);
    end
  end
  assign rx_ready_o  = ready_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign core_run_o  = run_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign word_cnt_o  = cnt_q;
endmodule

// File: tb/tb_imem_boot_loader_ctrl.sv
// tb_imem_boot_loader_ctrl: directed and randomized frames checked against a byte-level
// model of the framing, packing and overflow rules.
module tb_imem_boot_loader_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int M_IDLE = 0, M_LOAD = 1, M_ESC = 2, M_DONE = 3, M_ERR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte_i = 8'h0;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o, mem_we_o, core_run_o, busy_o, err_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [AW:0]   word_cnt_o;

  int n_chk = 0, n_fail = 0;
  int mst = M_IDLE, mcnt = 0;
  bit gaps_en = 1'b0;
  logic prev_we = 1'b0;
  logic [7:0]  pl[$];
  logic [37:0] exp_wr[$], got[$];
  logic [7:0]  s[$];

  imem_boot_loader_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .core_run_o(core_run_o), .busy_o(busy_o),
    .err_o(err_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we_o) begin
      chk("we_gap", 64'(prev_we), 64'(0));
      got.push_back({mem_addr_o, mem_wdata_o});
    end
    prev_we = rst_n & mem_we_o;
  end

  task automatic m_payload(input logic [7:0] b);
    int n;
    if (pl.size() == DEPTH * 4) begin
      mst = M_ERR;
      return;
    end
    pl.push_back(b);
    n = pl.size();
    if (n % 4 == 0) begin
      exp_wr.push_back({6'(n / 4 - 1), pl[n-4], pl[n-3], pl[n-2], pl[n-1]});
      mcnt = n / 4;
    end
  endtask

  task automatic model(input logic [7:0] b);
    int n;
    logic [31:0] w;
    case (mst)
      M_LOAD: begin
        if (b == 8'hFD) mst = M_ESC;
        else if (b == 8'hFE) mst = M_ERR;
        else if (b == 8'hFF) begin
          n = pl.size();
          if (n % 4 != 0) begin
            w = 32'h0;
            for (int i = 0; i < n % 4; i++) w[31-8*i -: 8] = pl[n - n % 4 + i];
            exp_wr.push_back({6'(n / 4), w});
            mcnt = n / 4 + 1;
          end
          mst = M_DONE;
        end else m_payload(b);
      end
      M_ESC: begin
        m_payload(b);
        if (mst != M_ERR) mst = M_LOAD;
      end
      default: if (b == 8'hFE) begin
        mst = M_LOAD;
        pl.delete();
        mcnt = 0;
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    if (gaps_en && $urandom_range(0, 3) == 0) @(negedge clk);
    rx_byte_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'(n), 64'(0));
    model(b);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_s();
    foreach (s[i]) send(s[i]);
    s.delete();
  endtask

  task automatic cmp_wr(input string tag);
    chk({tag, "_nwr"}, 64'(got.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got.size() && i < exp_wr.size(); i++)
      chk({tag, "_wr"}, 64'(got[i]), 64'(exp_wr[i]));
    got.delete();
    exp_wr.delete();
  endtask

  task automatic settle(input string tag);
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    cmp_wr(tag);
    chk({tag, "_run"},  64'(core_run_o), 64'(mst == M_DONE));
    chk({tag, "_err"},  64'(err_o),      64'(mst == M_ERR));
    chk({tag, "_busy"}, 64'(busy_o),     64'(mst == M_LOAD || mst == M_ESC));
    chk({tag, "_cnt"},  64'(word_cnt_o), 64'(mcnt));
    chk({tag, "_rdy"},  64'(rx_ready_o), 64'(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  64'(rx_ready_o),  64'(0));
    chk({tag, "_we"},   64'(mem_we_o),    64'(0));
    chk({tag, "_addr"}, 64'(mem_addr_o),  64'(0));
    chk({tag, "_data"}, 64'(mem_wdata_o), 64'(0));
    chk({tag, "_run"},  64'(core_run_o),  64'(0));
    chk({tag, "_busy"}, 64'(busy_o),      64'(0));
    chk({tag, "_err"},  64'(err_o),       64'(0));
    chk({tag, "_cnt"},  64'(word_cnt_o),  64'(0));
  endtask

  initial begin
    logic [7:0] b;
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    settle("idle");

    s = '{8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_s();
    send(8'hFF);
    chk("t1_flush_rdy",  64'(rx_ready_o), 64'(0));
    chk("t1_flush_busy", 64'(busy_o),     64'(1));
    chk("t1_flush_run",  64'(core_run_o), 64'(0));
    chk("t1_flush_we",   64'(mem_we_o),   64'(0));
    @(negedge clk);
    chk("t1_run", 64'(core_run_o), 64'(1));
    settle("t1");

    s = '{8'hFE, 8'hAA, 8'hBB};
    send_s();
    send(8'hFF);
    chk("t2_flush_we",   64'(mem_we_o),    64'(1));
    chk("t2_flush_data", 64'(mem_wdata_o), 64'h0000_0000_AABB_0000);
    chk("t2_flush_addr", 64'(mem_addr_o),  64'(0));
    settle("t2");

    s = '{8'hFE, 8'hFD, 8'hFF, 8'hFD, 8'hFE, 8'hFD, 8'hFD, 8'h11, 8'hFF};
    send_s();
    chk("t3_model_word", 64'(exp_wr.size() == 1 ? exp_wr[0][31:0] : 32'h0), 64'h0000_0000_FFFE_FD11);
    settle("t3");

    send(8'hFE);
    for (int i = 0; i < DEPTH * 4; i++) send(8'($urandom_range(0, 252)));
    send(8'h42);
    chk("t4_err", 64'(err_o), 64'(1));
    chk("t4_run", 64'(core_run_o), 64'(0));
    send(8'h43);
    send(8'hFF);
    settle("t4");
    send(8'hFE);
    chk("t4_err_clr", 64'(err_o), 64'(0));
    send(8'hFF);
    settle("t4_empty");

    s = '{8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    send_s();
    settle("t5a");
    send(8'hFE);
    chk("t5_run_drop", 64'(core_run_o), 64'(0));
    s = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF};
    send_s();
    settle("t5b");

    s = '{8'hFE, 8'h11, 8'h22, 8'h33, 8'hFF, 8'hFE, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    send_s();
    rx_byte_i  = 8'hBB;
    rx_valid_i = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_rst");
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    cmp_wr("t6");
    mst  = M_IDLE;
    mcnt = 0;
    rst_n = 1'b1;
    settle("t6_post");

    gaps_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        s.push_back(b == 8'hFE ? 8'h00 : b);
      end
      s.push_back(8'hFE);
      repeat ($urandom_range(0, 24)) begin
        b = 8'($urandom_range(0, 255));
        if (b >= 8'hFD) s.push_back(8'hFD);
        s.push_back(b);
        if ($urandom_range(0, 40) == 0) s.push_back(8'hFE);
      end
      s.push_back(8'hFF);
      send_s();
      settle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
